// File: rtl/shift_add_multiplier_if.sv
// Start/Done handshake bundle between the shift-add multiplier and its requester.
// The requester drives the operands; the multiplier returns status and the product.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   mult_a;
  logic [WIDTH-1:0]   mult_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, mult_a, mult_b,
    input  busy, done, product
  );

  modport slave (
    input  start, mult_a, mult_b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial product per RUN cycle,
// WIDTH RUN cycles then a one-cycle DONE pulse carrying the registered product.
module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_add_multiplier_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_next;

  always_comb begin
    acc_next = acc_q;
    if (mplier_q[0]) acc_next = acc_q + mcand_q;
  end

  // DONE accepts a new request just like IDLE, which gives back-to-back operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.mult_a};
            mplier_q <= bus.mult_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            product_q <= acc_next;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: latency, busy window, products,
// ignored mid-run requests, back-to-back starts and mid-run reset abort.
module tb_shift_add_multiplier;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] lastProduct = '0;

  shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  shift_add_multiplier #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Raise start for one sampling edge; unless held, scramble operands after capture.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit holdStart);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mult_a = a;
    bus.mult_b = b;
    @(negedge clk);
    if (!holdStart) begin
      bus.start  = 1'b0;
      bus.mult_a = $urandom;
      bus.mult_b = $urandom;
    end
  endtask

  // Called one negedge after the accepting edge; returns on the DONE cycle.
  task automatic waitDone(input string tag, input logic [63:0] expProduct, input int pokeCycle);
    int cycles = 1;
    int busyCycles = 0;
    checkOutput({tag, " hold"}, bus.product, lastProduct);
    while (!bus.done && cycles < 100) begin
      if (bus.busy) busyCycles++;
      if (cycles == pokeCycle) begin
        bus.start  = 1'b1;
        bus.mult_a = 32'd1000;
        bus.mult_b = 32'd1000;
      end else if (cycles == pokeCycle + 1) begin
        bus.start  = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " latency"}, 64'(cycles), 64'd33);
    checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'd32);
    checkOutput({tag, " product"}, bus.product, expProduct);
    lastProduct = expProduct;
  endtask

  task automatic afterDone(input string tag);
    @(negedge clk);
    checkOutput({tag, " done drop"}, 64'(bus.done), 64'd0);
    checkOutput({tag, " busy idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int donePulses;
    bus.start  = 1'b0;
    bus.mult_a = '0;
    bus.mult_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset product", bus.product, 64'd0);
    rst_n = 1'b1;

    // 3 * 5
    applyStimulus(32'd3, 32'd5, 1'b0);
    waitDone("3x5", 64'h0F, -1);
    afterDone("3x5");

    // All-ones operands
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    waitDone("max", 64'hFFFFFFFE_00000001, -1);
    afterDone("max");

    // Zero operands keep full latency
    applyStimulus(32'd0, 32'h12345678, 1'b0);
    waitDone("zero a", 64'd0, -1);
    afterDone("zero a");
    applyStimulus(32'h9ABCDEF0, 32'd0, 1'b0);
    waitDone("zero b", 64'd0, -1);
    afterDone("zero b");

    // Start during RUN is ignored
    applyStimulus(32'd11, 32'd13, 1'b0);
    waitDone("poke", 64'd143, 10);
    afterDone("poke");
    donePulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) donePulses++;
    end
    checkOutput("poke extra done", 64'(donePulses), 64'd0);

    // Start held high: back-to-back operations
    applyStimulus(32'd7, 32'd9, 1'b1);
    bus.mult_a = 32'd2;
    bus.mult_b = 32'h80000000;
    waitDone("b2b first", 64'd63, -1);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("b2b second", 64'h1_00000000, -1);
    afterDone("b2b second");

    // Reset mid-RUN aborts
    applyStimulus(32'h0000FFFF, 32'd3, 1'b0);
    repeat (15) @(negedge clk);
    checkOutput("abort busy before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(bus.busy), 64'd0);
    checkOutput("abort product", bus.product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lastProduct = '0;
    donePulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) donePulses++;
    end
    checkOutput("abort no done", 64'(donePulses), 64'd0);
    checkOutput("abort product held", bus.product, 64'd0);

    // Recovery after abort
    applyStimulus(32'd6, 32'd7, 1'b0);
    waitDone("6x7", 64'd42, -1);
    afterDone("6x7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
